// File: rtl/rx_frame_gate.sv
// Receive-side frame gate: strips preamble/SFD, enforces MIN_LEN/MAX_LEN,
// drops frames on link loss and keeps saturating good/bad frame counters.
module rx_frame_gate #(
    parameter int MIN_LEN   = 64,
    parameter int MAX_LEN   = 1518,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 link_sync,
    input  logic [7:0]           rx_data_i,
    input  logic                 rx_ctrl_i,
    output logic [7:0]           rx_data,
    output logic                 rx_ctrl,
    output logic                 runt,
    output logic                 giant,
    output logic                 aborted,
    output logic [CNT_WIDTH-1:0] frames_ok,
    output logic [CNT_WIDTH-1:0] frames_bad
);

    localparam logic [7:0]  PRE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE = 8'hD5;
    localparam logic [10:0] MIN_L    = 11'(MIN_LEN);
    localparam logic [10:0] MAX_L    = 11'(MAX_LEN);

    typedef enum logic [1:0] {IDLE, PREAMBLE, FRAME, DISCARD} state_t;

    state_t      state;
    logic [2:0]  pre_cnt;
    logic [10:0] len;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            pre_cnt    <= '0;
            len        <= '0;
            rx_data    <= '0;
            rx_ctrl    <= 1'b0;
            runt       <= 1'b0;
            giant      <= 1'b0;
            aborted    <= 1'b0;
            frames_ok  <= '0;
            frames_bad <= '0;
        end else begin
            rx_data <= '0;
            rx_ctrl <= 1'b0;
            runt    <= 1'b0;
            giant   <= 1'b0;
            aborted <= 1'b0;
            case (state)
                IDLE: begin
                    if (rx_ctrl_i) begin
                        if (link_sync && rx_data_i == PRE_BYTE) begin
                            state   <= PREAMBLE;
                            pre_cnt <= 3'd1;
                        end else begin
                            state      <= DISCARD;
                            aborted    <= 1'b1;
                            frames_bad <= sat_inc(frames_bad);
                        end
                    end
                end
                PREAMBLE: begin
                    // pre_cnt is always 1..7 here, so any SFD is accepted
                    if (rx_ctrl_i && link_sync && rx_data_i == SFD_BYTE) begin
                        state <= FRAME;
                        len   <= '0;
                    end else if (rx_ctrl_i && link_sync && rx_data_i == PRE_BYTE
                                 && pre_cnt != 3'd7) begin
                        pre_cnt <= pre_cnt + 3'd1;
                    end else begin
                        state      <= DISCARD;
                        aborted    <= 1'b1;
                        frames_bad <= sat_inc(frames_bad);
                    end
                end
                FRAME: begin
                    if (!rx_ctrl_i) begin
                        state <= IDLE;
                        if (len < MIN_L) begin
                            runt       <= 1'b1;
                            frames_bad <= sat_inc(frames_bad);
                        end else begin
                            frames_ok <= sat_inc(frames_ok);
                        end
                    end else if (!link_sync) begin
                        state      <= DISCARD;
                        aborted    <= 1'b1;
                        frames_bad <= sat_inc(frames_bad);
                    end else if (len == MAX_L) begin
                        // counter stops here; the over-length byte is dropped
                        state      <= DISCARD;
                        giant      <= 1'b1;
                        frames_bad <= sat_inc(frames_bad);
                    end else begin
                        len     <= len + 11'd1;
                        rx_data <= rx_data_i;
                        rx_ctrl <= 1'b1;
                    end
                end
                DISCARD: begin
                    if (!rx_ctrl_i && link_sync) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rx_frame_gate.sv
// Directed bench for rx_frame_gate: frame-level expectation queue checked every
// cycle, plus a CNT_WIDTH=2 instance for counter saturation.
module tb_rx_frame_gate;

    localparam int MIN_LEN = 64;
    localparam int MAX_LEN = 1518;

    logic        clk, reset, link_sync, rx_ctrl_i;
    logic [7:0]  rx_data_i;
    logic [7:0]  rx_data, d2_rx_data;
    logic        rx_ctrl, runt, giant, aborted;
    logic        d2_rx_ctrl, d2_runt, d2_giant, d2_aborted;
    logic [15:0] frames_ok, frames_bad;
    logic [1:0]  d2_ok, d2_bad;

    rx_frame_gate #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN), .CNT_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .link_sync(link_sync),
        .rx_data_i(rx_data_i), .rx_ctrl_i(rx_ctrl_i),
        .rx_data(rx_data), .rx_ctrl(rx_ctrl),
        .runt(runt), .giant(giant), .aborted(aborted),
        .frames_ok(frames_ok), .frames_bad(frames_bad)
    );

    rx_frame_gate #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN), .CNT_WIDTH(2)) dut2 (
        .clk(clk), .reset(reset), .link_sync(link_sync),
        .rx_data_i(rx_data_i), .rx_ctrl_i(rx_ctrl_i),
        .rx_data(d2_rx_data), .rx_ctrl(d2_rx_ctrl),
        .runt(d2_runt), .giant(d2_giant), .aborted(d2_aborted),
        .frames_ok(d2_ok), .frames_bad(d2_bad)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       c;
        logic [7:0] d;
        logic       r, g, a;
        int         ok, bad;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int n_checks = 0, n_err = 0;
    int n_ok = 0, n_bad = 0;
    int fwd_seen = 0, runt_seen = 0, giant_seen = 0, abort_seen = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endfunction

    function automatic logic [15:0] sat16(input int n);
        return (n > 65535) ? 16'hFFFF : 16'(n);
    endfunction

    function automatic logic [1:0] sat2(input int n);
        return (n > 3) ? 2'd3 : 2'(n);
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("cycle", {rx_ctrl, rx_data, runt, giant, aborted, frames_ok, frames_bad},
                  {e.c, e.d, e.r, e.g, e.a, sat16(e.ok), sat16(e.bad)});
            check("cycle_w2", {d2_rx_ctrl, d2_rx_data, d2_runt, d2_giant, d2_aborted, d2_ok, d2_bad},
                  {e.c, e.d, e.r, e.g, e.a, sat2(e.ok), sat2(e.bad)});
            fwd_seen   += int'(rx_ctrl);
            runt_seen  += int'(runt);
            giant_seen += int'(giant);
            abort_seen += int'(aborted);
        end
    end

    // One input cycle; the expectation is the output visible after its clock edge.
    task automatic step(input logic lk, input logic c, input logic [7:0] d,
                        input logic xc, input logic [7:0] xd,
                        input logic xr, input logic xg, input logic xa, input logic xok);
        exp_t x;
        link_sync = lk;
        rx_ctrl_i = c;
        rx_data_i = d;
        if (xr || xg || xa) n_bad++;
        if (xok) n_ok++;
        x = '{xc, xd, xr, xg, xa, n_ok, n_bad};
        exp_q.push_back(x);
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic quiet(input logic lk, input logic c, input logic [7:0] d);
        step(lk, c, d, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic clr_seen();
        fwd_seen = 0; runt_seen = 0; giant_seen = 0; abort_seen = 0;
    endtask

    // Complete frame with link up; outcome follows from length alone.
    task automatic good_frame(input int npre, input int len);
        for (int p = 0; p < npre; p++) quiet(1'b1, 1'b1, 8'h55);
        quiet(1'b1, 1'b1, 8'hD5);
        for (int i = 0; i < len; i++) begin
            if (i < MAX_LEN)
                step(1'b1, 1'b1, 8'(i), 1'b1, 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
            else if (i == MAX_LEN)
                step(1'b1, 1'b1, 8'(i), 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
            else
                quiet(1'b1, 1'b1, 8'(i));
        end
        step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, (len < MIN_LEN), 1'b0, 1'b0,
             (len >= MIN_LEN && len <= MAX_LEN));
    endtask

    initial begin
        reset = 1'b1; link_sync = 1'b1; rx_ctrl_i = 1'b0; rx_data_i = 8'h00;
        @(posedge clk); @(posedge clk); @(negedge clk);
        check("reset_out", {rx_ctrl, rx_data, runt, giant, aborted, frames_ok, frames_bad}, 64'd0);
        check("reset_out_w2", {d2_rx_ctrl, d2_rx_data, d2_ok, d2_bad}, 64'd0);
        #1 reset = 1'b0;
        quiet(1'b1, 1'b0, 8'h00);

        clr_seen(); good_frame(7, 64);
        check("f64_fwd", fwd_seen, 64);
        check("f64_ok", frames_ok, 1);
        check("f64_flags", runt_seen + giant_seen + abort_seen, 0);

        clr_seen(); good_frame(7, 40);
        check("runt_fwd", fwd_seen, 40);
        check("runt_pulse", runt_seen, 1);
        check("runt_bad", frames_bad, 1);
        check("runt_ok_unchanged", frames_ok, 1);

        clr_seen(); good_frame(7, 1600);
        check("giant_fwd", fwd_seen, 1518);
        check("giant_pulse", giant_seen, 1);
        check("giant_bad", frames_bad, 2);

        // link loss at the 20th frame byte, then DISCARD must hold
        clr_seen();
        for (int p = 0; p < 7; p++) quiet(1'b1, 1'b1, 8'h55);
        quiet(1'b1, 1'b1, 8'hD5);
        for (int i = 0; i < 19; i++)
            step(1'b1, 1'b1, 8'(i), 1'b1, 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'h13, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) quiet(1'b0, 1'b1, 8'(20 + i));
        for (int i = 0; i < 3; i++) quiet(1'b1, 1'b1, 8'(30 + i));
        quiet(1'b0, 1'b0, 8'h00);
        quiet(1'b0, 1'b0, 8'h00);
        for (int p = 0; p < 3; p++) quiet(1'b1, 1'b1, 8'h55);
        quiet(1'b1, 1'b1, 8'hD5);
        for (int i = 0; i < 4; i++) quiet(1'b1, 1'b1, 8'(i));
        quiet(1'b1, 1'b0, 8'h00);
        check("drop_fwd", fwd_seen, 19);
        check("drop_abort", abort_seen, 1);
        check("drop_bad", frames_bad, 3);

        // bad preamble, then an intact frame right after
        clr_seen();
        quiet(1'b1, 1'b1, 8'h55);
        quiet(1'b1, 1'b1, 8'h55);
        step(1'b1, 1'b1, 8'hAA, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int p = 0; p < 3; p++) quiet(1'b1, 1'b1, 8'h55);
        quiet(1'b1, 1'b1, 8'hD5);
        for (int i = 0; i < 5; i++) quiet(1'b1, 1'b1, 8'(i));
        quiet(1'b1, 1'b0, 8'h00);
        check("badpre_abort", abort_seen, 1);
        check("badpre_fwd", fwd_seen, 0);
        clr_seen(); good_frame(7, 64);
        check("after_badpre_fwd", fwd_seen, 64);
        check("after_badpre_ok", frames_ok, 2);

        good_frame(1, 64);
        for (int p = 0; p < 7; p++) quiet(1'b1, 1'b1, 8'h55);
        step(1'b1, 1'b1, 8'h55, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        quiet(1'b1, 1'b1, 8'hD5);
        for (int i = 0; i < 10; i++) quiet(1'b1, 1'b1, 8'(i));
        quiet(1'b1, 1'b0, 8'h00);
        clr_seen(); good_frame(7, 1518);
        check("max_fwd", fwd_seen, 1518);
        check("max_nogiant", giant_seen, 0);
        good_frame(7, 63);
        good_frame(7, 0);
        clr_seen(); good_frame(7, 1519);
        check("max1_fwd", fwd_seen, 1518);
        check("max1_giant", giant_seen, 1);
        check("tally_ok", frames_ok, 4);
        check("tally_bad", frames_bad, 8);

        for (int f = 0; f < 5; f++) good_frame(7, 64);
        check("sat_ok16", frames_ok, 9);
        check("sat_ok2", d2_ok, 3);
        check("sat_bad2", d2_bad, 3);

        // reset in the middle of a forwarding frame
        for (int p = 0; p < 7; p++) quiet(1'b1, 1'b1, 8'h55);
        quiet(1'b1, 1'b1, 8'hD5);
        for (int i = 0; i < 10; i++)
            step(1'b1, 1'b1, 8'(i), 1'b1, 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
        rx_data_i = 8'h0A;
        #2 reset = 1'b1;
        #1;
        check("midrst_now", {rx_ctrl, rx_data, runt, giant, aborted, frames_ok, frames_bad}, 64'd0);
        check("midrst_now_w2", {d2_rx_ctrl, d2_rx_data, d2_ok, d2_bad}, 64'd0);
        n_ok = 0; n_bad = 0;
        @(posedge clk); @(negedge clk);
        check("midrst_held", {rx_ctrl, rx_data, runt, giant, aborted, frames_ok, frames_bad}, 64'd0);
        #1 reset = 1'b0;
        clr_seen();
        step(1'b1, 1'b1, 8'h0B, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) quiet(1'b1, 1'b1, 8'(12 + i));
        quiet(1'b1, 1'b0, 8'h00);
        check("postrst_abort", abort_seen, 1);
        good_frame(7, 64);
        check("postrst_ok", frames_ok, 1);
        check("postrst_bad", frames_bad, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
